// File: rtl/computational_unit.sv
// Computational unit: working registers, data-bus source mux, ALU and
// data-memory interface sitting directly below the instruction decoder.
// Every read uses the register values from before the clock edge, so a
// register can be both a bus source and a load target in the same cycle.
module computational_unit #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sync_reset,
  input  logic [8:0]    register_enables,
  input  logic [3:0]    source_register_select,
  input  logic [3:0]    LS_nibble_of_ir,
  input  logic [2:0]    alu_func,
  input  logic          x_mux_select,
  input  logic          y_mux_select,
  input  logic          i_mux_select,
  input  logic [DW-1:0] dm_read_data,
  output logic [DW-1:0] data_bus,
  output logic [DW-1:0] dm_address,
  output logic          dm_write,
  output logic [DW-1:0] dm_write_data,
  output logic [DW-1:0] o_reg,
  output logic [DW-1:0] r_out,
  output logic          zero_flag
);

  localparam int EN_X0 = 0;
  localparam int EN_X1 = 1;
  localparam int EN_Y0 = 2;
  localparam int EN_Y1 = 3;
  localparam int EN_O  = 4;
  localparam int EN_M  = 5;
  localparam int EN_I  = 6;
  localparam int EN_DM = 7;
  localparam int EN_R  = 8;

  typedef enum logic [2:0] {
    ALU_NEG = 3'd0,
    ALU_SUB = 3'd1,
    ALU_ADD = 3'd2,
    ALU_MUL = 3'd3,
    ALU_XOR = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_NOT = 3'd7
  } alu_op_e;

  logic [DW-1:0] x0_q, x0_d;
  logic [DW-1:0] x1_q, x1_d;
  logic [DW-1:0] y0_q, y0_d;
  logic [DW-1:0] y1_q, y1_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] m_q, m_d;
  logic [DW-1:0] i_q, i_d;
  logic [DW-1:0] o_q, o_d;
  logic          zf_q, zf_d;

  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] alu_result;
  logic [7:0]    nibble_product;
  logic [DW-1:0] immediate;
  logic [DW-1:0] i_plus_m;
  alu_op_e       alu_op;

  assign immediate = {{(DW-4){1'b0}}, LS_nibble_of_ir};
  assign alu_op    = alu_op_e'(alu_func);

  // Data-bus source selection; unused codes drive zero.
  always_comb begin
    data_bus = '0;
    unique case (source_register_select)
      4'd0:    data_bus = x0_q;
      4'd1:    data_bus = x1_q;
      4'd2:    data_bus = y0_q;
      4'd3:    data_bus = y1_q;
      4'd4:    data_bus = r_q;
      4'd5:    data_bus = m_q;
      4'd6:    data_bus = i_q;
      4'd7:    data_bus = dm_read_data;
      4'd8:    data_bus = immediate;
      default: data_bus = '0;
    endcase
  end

  // ALU operand selection and combinational result.
  always_comb begin
    alu_x          = x_mux_select ? x1_q : x0_q;
    alu_y          = y_mux_select ? y1_q : y0_q;
    nibble_product = alu_x[3:0] * alu_y[3:0];
    alu_result     = '0;
    unique case (alu_op)
      ALU_NEG: alu_result = '0 - alu_x;
      ALU_SUB: alu_result = alu_x - alu_y;
      ALU_ADD: alu_result = alu_x + alu_y;
      ALU_MUL: alu_result = DW'(nibble_product);
      ALU_XOR: alu_result = alu_x ^ alu_y;
      ALU_AND: alu_result = alu_x & alu_y;
      ALU_OR:  alu_result = alu_x | alu_y;
      ALU_NOT: alu_result = ~alu_x;
      default: alu_result = '0;
    endcase
  end

  // Post-increment address arithmetic wraps modulo 2**DW.
  assign i_plus_m = i_q + m_q;

  // Next-state for every register: hold unless its enable is set;
  // sync_reset overrides all loads.
  always_comb begin
    x0_d = x0_q;
    x1_d = x1_q;
    y0_d = y0_q;
    y1_d = y1_q;
    r_d  = r_q;
    m_d  = m_q;
    i_d  = i_q;
    o_d  = o_q;
    zf_d = zf_q;
    if (sync_reset) begin
      x0_d = '0;
      x1_d = '0;
      y0_d = '0;
      y1_d = '0;
      r_d  = '0;
      m_d  = '0;
      i_d  = '0;
      o_d  = '0;
      zf_d = 1'b0;
    end else begin
      if (register_enables[EN_X0]) x0_d = data_bus;
      if (register_enables[EN_X1]) x1_d = data_bus;
      if (register_enables[EN_Y0]) y0_d = data_bus;
      if (register_enables[EN_Y1]) y1_d = data_bus;
      if (register_enables[EN_O])  o_d  = data_bus;
      if (register_enables[EN_M])  m_d  = data_bus;
      if (register_enables[EN_I])  i_d  = i_mux_select ? i_plus_m : data_bus;
      if (register_enables[EN_R]) begin
        r_d  = alu_result;
        zf_d = (alu_result == '0);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q <= '0;
      x1_q <= '0;
      y0_q <= '0;
      y1_q <= '0;
      r_q  <= '0;
      m_q  <= '0;
      i_q  <= '0;
      o_q  <= '0;
      zf_q <= 1'b0;
    end else begin
      x0_q <= x0_d;
      x1_q <= x1_d;
      y0_q <= y0_d;
      y1_q <= y1_d;
      r_q  <= r_d;
      m_q  <= m_d;
      i_q  <= i_d;
      o_q  <= o_d;
      zf_q <= zf_d;
    end
  end

  assign dm_address    = i_q;
  assign dm_write      = register_enables[EN_DM];
  assign dm_write_data = data_bus;
  assign o_reg         = o_q;
  assign r_out         = r_q;
  assign zero_flag     = zf_q;

endmodule
